memory_mapped_regs: RTL and testbench

Memory-mapped configuration and status register bank for the MPEG2-TS QoS channel-selection controller. A host writes selection policy fields (fallback, manual override, priority order, re-evaluation timer) and commits them. Committing pulses valid_config to the main control FSM. Live status is read back: active channel, per-channel signal presence and per-channel 8-bit error counts.

---
 rtl/memory_mapped_regs.sv | 122 ++++++++++++
 tb/tb_memory_mapped_regs.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_mapped_regs.sv
// Host-visible configuration/status register bank for the TS QoS channel selector.
// Policy fields drive straight from flops; COMMIT validates the priority order and pulses valid_config.
module memory_mapped_regs #(
  parameter logic [19:0] RESET_TIMER_DEFAULT = 20'd1000,
  parameter logic [7:0]  PRIORITY_DEFAULT    = 8'hE4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mm_write_en,
  input  logic        mm_read_en,
  input  logic [7:0]  mm_addr,
  input  logic [31:0] mm_wdata,
  output logic [31:0] mm_rdata,
  output logic        fallback_enable,
  output logic        manual_enable,
  output logic [1:0]  manual_channel,
  output logic [7:0]  channel_priority,
  output logic [19:0] reset_timer,
  output logic        valid_config,
  input  logic [1:0]  active_channel,
  input  logic [3:0]  signal_present,
  input  logic [7:0]  error_count_ch0,
  input  logic [7:0]  error_count_ch1,
  input  logic [7:0]  error_count_ch2,
  input  logic [7:0]  error_count_ch3
);
  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  localparam logic [5:0] A_CONTROL  = 6'h00;
  localparam logic [5:0] A_PRIORITY = 6'h01;
  localparam logic [5:0] A_TIMER    = 6'h02;
  localparam logic [5:0] A_COMMIT   = 6'h03;
  localparam logic [5:0] A_STATUS   = 6'h04;
  localparam logic [5:0] A_ERRCNT   = 6'h05;

  typedef struct packed {
    logic        wr;
    logic        rd;
    logic [5:0]  idx;
    logic [31:0] wdata;
  } mm_req_t;

  mm_req_t                         req;
  logic [3:0]                      ctrl_q;
  logic [NUM_CH-1:0][CH_W-1:0]     prio_q;
  logic [19:0]                     timer_q;
  logic                            cfg_err_q;
  logic [NUM_CH-1:0][7:0]          err_cnt;
  logic [NUM_CH-1:0][NUM_CH-1:0]   prio_onehot;
  logic [NUM_CH-1:0]               prio_seen;
  logic                            prio_ok;
  logic                            commit_req;
  logic [31:0]                     rd_val;
  logic                            unused_ok;

  assign req = '{wr: mm_write_en, rd: mm_read_en, idx: mm_addr[7:2], wdata: mm_wdata};
  assign err_cnt = {error_count_ch3, error_count_ch2, error_count_ch1, error_count_ch0};
  assign unused_ok = ^{mm_addr[1:0], req.wdata[31:20]};

  assign fallback_enable  = ctrl_q[0];
  assign manual_enable    = ctrl_q[1];
  assign manual_channel   = ctrl_q[3:2];
  assign channel_priority = prio_q;
  assign reset_timer      = timer_q;

  // Four ids are pairwise distinct exactly when their one-hot decodes cover every channel.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_prio_dec
    assign prio_onehot[g] = {{(NUM_CH-1){1'b0}}, 1'b1} << prio_q[g];
  end

  always_comb begin
    prio_seen = '0;
    for (int i = 0; i < NUM_CH; i++) prio_seen = prio_seen | prio_onehot[i];
    prio_ok = &prio_seen;
  end

  assign commit_req = req.wr && (req.idx == A_COMMIT) && req.wdata[0];

  // Read mux sees pre-write register values, so a same-cycle write is not visible.
  always_comb begin
    rd_val = '0;
    case (req.idx)
      A_CONTROL:  rd_val[3:0]  = ctrl_q;
      A_PRIORITY: rd_val[7:0]  = prio_q;
      A_TIMER:    rd_val[19:0] = timer_q;
      A_STATUS: begin
        rd_val[1:0] = active_channel;
        rd_val[7:4] = signal_present;
        rd_val[8]   = cfg_err_q;
      end
      A_ERRCNT:   rd_val = err_cnt;
      default:    rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q       <= '0;
      prio_q       <= PRIORITY_DEFAULT;
      timer_q      <= RESET_TIMER_DEFAULT;
      cfg_err_q    <= 1'b0;
      valid_config <= 1'b0;
      mm_rdata     <= '0;
    end else begin
      valid_config <= 1'b0;
      if (req.wr) begin
        case (req.idx)
          A_CONTROL:  ctrl_q  <= req.wdata[3:0];
          A_PRIORITY: prio_q  <= req.wdata[7:0];
          A_TIMER:    timer_q <= req.wdata[19:0];
          default: ;
        endcase
      end
      if (commit_req) begin
        valid_config <= prio_ok;
        cfg_err_q    <= !prio_ok;
      end
      mm_rdata <= req.rd ? rd_val : 32'h0;
    end
  end
endmodule

// File: tb/tb_memory_mapped_regs.sv
// Bench for memory_mapped_regs: directed vector table, reset/commit sequences, then random traffic vs a model.
module tb_memory_mapped_regs;
  logic        clk = 1'b0;
  logic        rst;
  logic        mm_write_en, mm_read_en;
  logic [7:0]  mm_addr;
  logic [31:0] mm_wdata, mm_rdata;
  logic        fallback_enable, manual_enable, valid_config;
  logic [1:0]  manual_channel, active_channel;
  logic [7:0]  channel_priority;
  logic [19:0] reset_timer;
  logic [3:0]  signal_present;
  logic [7:0]  error_count_ch0, error_count_ch1, error_count_ch2, error_count_ch3;

  always #5 clk = ~clk;

  memory_mapped_regs dut (
    .clk(clk), .rst(rst),
    .mm_write_en(mm_write_en), .mm_read_en(mm_read_en), .mm_addr(mm_addr),
    .mm_wdata(mm_wdata), .mm_rdata(mm_rdata),
    .fallback_enable(fallback_enable), .manual_enable(manual_enable),
    .manual_channel(manual_channel), .channel_priority(channel_priority),
    .reset_timer(reset_timer), .valid_config(valid_config),
    .active_channel(active_channel), .signal_present(signal_present),
    .error_count_ch0(error_count_ch0), .error_count_ch1(error_count_ch1),
    .error_count_ch2(error_count_ch2), .error_count_ch3(error_count_ch3)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state (register-level view of the host interface)
  logic [3:0]  m_ctrl;
  logic [7:0]  m_prio;
  logic [19:0] m_timer;
  logic        m_err;
  logic [31:0] m_rdata;
  logic        m_vc;

  typedef struct {
    logic        we;
    logic        re;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_vc;
    logic [3:0]  exp_ctrl;
    logic [7:0]  exp_prio;
    logic [19:0] exp_timer;
  } vec_t;

  vec_t vecs[$];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit prio_distinct(logic [7:0] p);
    for (int i = 0; i < 4; i++)
      for (int j = i + 1; j < 4; j++)
        if (p[2*i +: 2] == p[2*j +: 2]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] model_read(logic [7:0] a);
    case (a / 8'd4)
      8'd0: return {28'h0, m_ctrl};
      8'd1: return {24'h0, m_prio};
      8'd2: return {12'h0, m_timer};
      8'd4: return {23'h0, m_err, signal_present, 2'b00, active_channel};
      8'd5: return {error_count_ch3, error_count_ch2, error_count_ch1, error_count_ch0};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_ctrl = 4'h0; m_prio = 8'hE4; m_timer = 20'd1000;
    m_err = 1'b0; m_rdata = 32'h0; m_vc = 1'b0;
  endtask

  // Drive one access, advance the model by the same clock edge, sample 2ns after the edge.
  task automatic step(logic we, logic re, logic [7:0] a, logic [31:0] d);
    mm_write_en = we; mm_read_en = re; mm_addr = a; mm_wdata = d;
    if (rst) model_reset();
    else begin
      m_rdata = re ? model_read(a) : 32'h0;
      m_vc = 1'b0;
      if (we) begin
        case (a / 8'd4)
          8'd0: m_ctrl  = d[3:0];
          8'd1: m_prio  = d[7:0];
          8'd2: m_timer = d[19:0];
          8'd3: if (d[0]) begin m_vc = prio_distinct(m_prio); m_err = !m_vc; end
          default: ;
        endcase
      end
    end
    @(posedge clk);
    #2;
  endtask

  task automatic check_model(string tag);
    check({tag, "_rdata"}, mm_rdata, m_rdata);
    check({tag, "_vc"}, {31'h0, valid_config}, {31'h0, m_vc});
    check({tag, "_ctrl"}, {28'h0, manual_channel, manual_enable, fallback_enable}, {28'h0, m_ctrl});
    check({tag, "_prio"}, {24'h0, channel_priority}, {24'h0, m_prio});
    check({tag, "_timer"}, {12'h0, reset_timer}, {12'h0, m_timer});
  endtask

  task automatic add(logic we, logic re, logic [7:0] a, logic [31:0] d, logic [31:0] rd,
                     logic vc, logic [3:0] c, logic [7:0] p, logic [19:0] t);
    vec_t v;
    v.we = we; v.re = re; v.addr = a; v.wdata = d; v.exp_rdata = rd;
    v.exp_vc = vc; v.exp_ctrl = c; v.exp_prio = p; v.exp_timer = t;
    vecs.push_back(v);
  endtask

  initial begin
    add(1'b1, 1'b0, 8'h00, 32'hD,        32'h0,        1'b0, 4'hD, 8'hE4, 20'd1000);
    add(1'b1, 1'b0, 8'h04, 32'h1B,       32'h0,        1'b0, 4'hD, 8'h1B, 20'd1000);
    add(1'b1, 1'b0, 8'h08, 32'h64,       32'h0,        1'b0, 4'hD, 8'h1B, 20'd100);
    add(1'b0, 1'b1, 8'h00, 32'h0,        32'hD,        1'b0, 4'hD, 8'h1B, 20'd100);
    add(1'b0, 1'b1, 8'h04, 32'h0,        32'h1B,       1'b0, 4'hD, 8'h1B, 20'd100);
    add(1'b0, 1'b1, 8'h08, 32'h0,        32'h64,       1'b0, 4'hD, 8'h1B, 20'd100);
    add(1'b1, 1'b0, 8'h0C, 32'h1,        32'h0,        1'b1, 4'hD, 8'h1B, 20'd100);
    add(1'b0, 1'b1, 8'h10, 32'h0,        32'h0A2,      1'b0, 4'hD, 8'h1B, 20'd100);
    add(1'b1, 1'b0, 8'h04, 32'h05,       32'h0,        1'b0, 4'hD, 8'h05, 20'd100);
    add(1'b1, 1'b0, 8'h0C, 32'h1,        32'h0,        1'b0, 4'hD, 8'h05, 20'd100);
    add(1'b0, 1'b1, 8'h10, 32'h0,        32'h1A2,      1'b0, 4'hD, 8'h05, 20'd100);
    add(1'b1, 1'b0, 8'h04, 32'h1B,       32'h0,        1'b0, 4'hD, 8'h1B, 20'd100);
    add(1'b1, 1'b0, 8'h0C, 32'h1,        32'h0,        1'b1, 4'hD, 8'h1B, 20'd100);
    add(1'b0, 1'b1, 8'h10, 32'h0,        32'h0A2,      1'b0, 4'hD, 8'h1B, 20'd100);
    add(1'b0, 1'b1, 8'h14, 32'h0,        32'h44332211, 1'b0, 4'hD, 8'h1B, 20'd100);
    add(1'b1, 1'b0, 8'h10, 32'hFFFFFFFF, 32'h0,        1'b0, 4'hD, 8'h1B, 20'd100);
    add(1'b0, 1'b1, 8'h10, 32'h0,        32'h0A2,      1'b0, 4'hD, 8'h1B, 20'd100);
    add(1'b0, 1'b1, 8'h0C, 32'h0,        32'h0,        1'b0, 4'hD, 8'h1B, 20'd100);
    add(1'b0, 1'b1, 8'h3C, 32'h0,        32'h0,        1'b0, 4'hD, 8'h1B, 20'd100);
    add(1'b1, 1'b1, 8'h08, 32'h5,        32'h64,       1'b0, 4'hD, 8'h1B, 20'd5);
    add(1'b0, 1'b1, 8'h08, 32'h0,        32'h5,        1'b0, 4'hD, 8'h1B, 20'd5);
    add(1'b1, 1'b0, 8'h0C, 32'h0,        32'h0,        1'b0, 4'hD, 8'h1B, 20'd5);
    add(1'b0, 1'b1, 8'h01, 32'h0,        32'hD,        1'b0, 4'hD, 8'h1B, 20'd5);
    add(1'b1, 1'b0, 8'h0C, 32'h1,        32'h0,        1'b1, 4'hD, 8'h1B, 20'd5);
    add(1'b1, 1'b0, 8'h0C, 32'h1,        32'h0,        1'b1, 4'hD, 8'h1B, 20'd5);
    add(1'b0, 1'b0, 8'h10, 32'h0,        32'h0,        1'b0, 4'hD, 8'h1B, 20'd5);
    add(1'b1, 1'b0, 8'h00, 32'hFFFFFFFF, 32'h0,        1'b0, 4'hF, 8'h1B, 20'd5);
    add(1'b0, 1'b1, 8'h00, 32'h0,        32'hF,        1'b0, 4'hF, 8'h1B, 20'd5);
    add(1'b1, 1'b0, 8'h3C, 32'hFFFFFFFF, 32'h0,        1'b0, 4'hF, 8'h1B, 20'd5);
    add(1'b1, 1'b0, 8'h07, 32'hE4,       32'h0,        1'b0, 4'hF, 8'hE4, 20'd5);
    add(1'b0, 1'b1, 8'h04, 32'h0,        32'hE4,       1'b0, 4'hF, 8'hE4, 20'd5);

    rst = 1'b1;
    active_channel = 2'd2; signal_present = 4'hA;
    error_count_ch0 = 8'h11; error_count_ch1 = 8'h22;
    error_count_ch2 = 8'h33; error_count_ch3 = 8'h44;
    model_reset();

    // Reset values
    step(1'b0, 1'b0, 8'h00, 32'h0);
    step(1'b0, 1'b0, 8'h00, 32'h0);
    check("rst_fallback", {31'h0, fallback_enable}, 32'h0);
    check("rst_manual", {31'h0, manual_enable}, 32'h0);
    check("rst_mchan", {30'h0, manual_channel}, 32'h0);
    check("rst_prio", {24'h0, channel_priority}, 32'hE4);
    check("rst_timer", {12'h0, reset_timer}, 32'd1000);
    check("rst_vc", {31'h0, valid_config}, 32'h0);
    check("rst_rdata", mm_rdata, 32'h0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      step(vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wdata);
      check($sformatf("vec%0d_rdata", i), mm_rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d_vc", i), {31'h0, valid_config}, {31'h0, vecs[i].exp_vc});
      check($sformatf("vec%0d_ctrl", i), {28'h0, manual_channel, manual_enable, fallback_enable},
            {28'h0, vecs[i].exp_ctrl});
      check($sformatf("vec%0d_prio", i), {24'h0, channel_priority}, {24'h0, vecs[i].exp_prio});
      check($sformatf("vec%0d_timer", i), {12'h0, reset_timer}, {12'h0, vecs[i].exp_timer});
    end

    // Reset coinciding with a valid commit write: no pulse, fields back to defaults
    rst = 1'b1;
    step(1'b1, 1'b0, 8'h0C, 32'h1);
    check("rstcommit_vc", {31'h0, valid_config}, 32'h0);
    check("rstcommit_ctrl", {28'h0, manual_channel, manual_enable, fallback_enable}, 32'h0);
    rst = 1'b0;
    step(1'b0, 1'b0, 8'h00, 32'h0);
    check("rstcommit_after_vc", {31'h0, valid_config}, 32'h0);

    // Sticky config_error is cleared by reset
    step(1'b1, 1'b0, 8'h04, 32'h00);
    step(1'b1, 1'b0, 8'h0C, 32'h1);
    check("bad_commit_vc", {31'h0, valid_config}, 32'h0);
    step(1'b0, 1'b1, 8'h10, 32'h0);
    check("bad_commit_status", mm_rdata, 32'h1A2);
    rst = 1'b1;
    step(1'b0, 1'b0, 8'h00, 32'h0);
    rst = 1'b0;
    step(1'b0, 1'b1, 8'h10, 32'h0);
    check("rst_clears_err", mm_rdata, 32'h0A2);

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic        we, re;
      logic [7:0]  a;
      logic [31:0] d;
      logic [7:0]  p;
      active_channel  = 2'($urandom_range(0, 3));
      signal_present  = 4'($urandom_range(0, 15));
      error_count_ch0 = 8'($urandom_range(0, 255));
      error_count_ch1 = 8'($urandom_range(0, 255));
      error_count_ch2 = 8'($urandom_range(0, 255));
      error_count_ch3 = 8'($urandom_range(0, 255));
      rst = ($urandom_range(0, 49) == 0);
      we  = 1'($urandom_range(0, 1));
      re  = 1'($urandom_range(0, 1));
      a   = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 27));
      d   = $urandom();
      if ((a / 8'd4) == 8'd1 && $urandom_range(0, 1) == 1) begin
        p = 8'hE4;
        for (int k = 0; k < 4; k++) begin
          int j;
          logic [1:0] t;
          j = int'($urandom_range(0, 3));
          t = p[2*k +: 2];
          p[2*k +: 2] = p[2*j +: 2];
          p[2*j +: 2] = t;
        end
        d[7:0] = p;
      end
      if ((a / 8'd4) == 8'd3) d[0] = ($urandom_range(0, 3) != 0);
      step(we, re, a, d);
      check_model($sformatf("rnd%0d", n));
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
